// File: rtl/i2c_slave_pkg.sv
// rtl/i2c_slave_pkg.sv - shared FSM states and constants for the I2C register target
package i2c_slave_pkg;

    localparam int   BIT_CNT_W = 4;
    localparam logic I2C_ACK   = 1'b0;
    localparam logic I2C_NACK  = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WR,
        ST_WR_ACK,
        ST_RD,
        ST_RD_ACK,
        ST_IGNORE
    } i2c_state_t;

endpackage

// File: rtl/i2c_slave_line_cond.sv
// rtl/i2c_slave_line_cond.sv - SCL/SDA synchronizer, optional majority filter (I2C_SLAVE_GLITCH_FILTER_EN), edge and START/STOP detection
module i2c_slave_line_cond (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_raw,
    input  logic sda_raw,
    output logic scl,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_q;
    logic       sda_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl_raw};
            sda_sync <= {sda_sync[0], sda_raw};
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [2:0] scl_hist;
    logic [2:0] sda_hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_hist <= 3'b111;
            sda_hist <= 3'b111;
        end else begin
            scl_hist <= {scl_hist[1:0], scl_sync[1]};
            sda_hist <= {sda_hist[1:0], sda_sync[1]};
        end
    end

    // 2-of-3 vote: a single-cycle pulse never wins
    assign scl = (scl_hist[0] & scl_hist[1]) | (scl_hist[0] & scl_hist[2]) | (scl_hist[1] & scl_hist[2]);
    assign sda = (sda_hist[0] & sda_hist[1]) | (sda_hist[0] & sda_hist[2]) | (sda_hist[1] & sda_hist[2]);
`else
    assign scl = scl_sync[1];
    assign sda = sda_sync[1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl;
            sda_q <= sda;
        end
    end

    assign scl_rise  = scl & ~scl_q;
    assign scl_fall  = ~scl & scl_q;
    // SCL must be high on both samples so a data change at SCL fall is not misread
    assign start_det = scl & scl_q & sda_q & ~sda;
    assign stop_det  = scl & scl_q & ~sda_q & sda;

endmodule

// File: rtl/i2c_slave_regs.sv
// rtl/i2c_slave_regs.sv - I2C target bridging bus transactions to register strobes; filter option I2C_SLAVE_GLITCH_FILTER_EN
module i2c_slave_regs
    import i2c_slave_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR = 7'h42,
    parameter int         REG_AW   = 8
) (
    input  logic              wb_clk_i,
    input  logic              arst_i,
    input  logic              scl_pad_i,
    input  logic              sda_pad_i,
    output logic              sda_pad_o,
    output logic              sda_padoen_o,
    output logic [REG_AW-1:0] reg_addr_o,
    output logic [7:0]        reg_wdat_o,
    output logic              reg_wr_o,
    output logic              reg_rd_o,
    input  logic [7:0]        reg_rdat_i,
    output logic              busy_o
);

    logic scl, sda, scl_rise, scl_fall, start_det, stop_det;

    i2c_slave_line_cond u_line_cond (
        .clk       (wb_clk_i),
        .rst_n     (arst_i),
        .scl_raw   (scl_pad_i),
        .sda_raw   (sda_pad_i),
        .scl       (scl),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    i2c_state_t           state, state_nxt;
    logic [BIT_CNT_W-1:0] bit_cnt, cnt_nxt;
    logic [7:0]           shifter, shift_nxt;
    logic                 sda_oen, oen_nxt;
    logic [REG_AW-1:0]    ptr, ptr_nxt;
    logic [7:0]           wdat, wdat_nxt;
    logic                 reg_wr, wr_nxt;
    logic                 reg_rd, rd_nxt;
    logic                 busy, busy_nxt;
    logic                 ack_bit, ack_nxt;
    logic [7:0]           shift_in;
    logic                 byte_done;
    logic [2:0]           rd_idx;

    assign shift_in  = {shifter[6:0], sda};
    assign byte_done = (bit_cnt == BIT_CNT_W'(8));
    assign rd_idx    = 3'd7 - bit_cnt[2:0];

    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            shifter <= '0;
            sda_oen <= 1'b1;
            ptr     <= '0;
            wdat    <= '0;
            reg_wr  <= 1'b0;
            reg_rd  <= 1'b0;
            busy    <= 1'b0;
            ack_bit <= I2C_NACK;
        end else begin
            state   <= state_nxt;
            bit_cnt <= cnt_nxt;
            shifter <= shift_nxt;
            sda_oen <= oen_nxt;
            ptr     <= ptr_nxt;
            wdat    <= wdat_nxt;
            reg_wr  <= wr_nxt;
            reg_rd  <= rd_nxt;
            busy    <= busy_nxt;
            ack_bit <= ack_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = bit_cnt;
        shift_nxt = shifter;
        oen_nxt   = sda_oen;
        ptr_nxt   = ptr;
        wdat_nxt  = wdat;
        wr_nxt    = 1'b0;
        rd_nxt    = 1'b0;
        busy_nxt  = busy;
        ack_nxt   = ack_bit;

        // Pointer advances in the strobe cycle so the strobe sees the pre-increment address
        if (reg_wr || reg_rd)
            ptr_nxt = ptr + REG_AW'(1);
        if (reg_rd)
            shift_nxt = reg_rdat_i;

        if (stop_det) begin
            state_nxt = ST_IDLE;
            oen_nxt   = 1'b1;
            busy_nxt  = 1'b0;
        end else if (start_det) begin
            state_nxt = ST_ADDR;
            cnt_nxt   = '0;
            oen_nxt   = 1'b1;
            busy_nxt  = 1'b1;
        end else begin
            case (state)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_nxt = shift_in;
                        cnt_nxt   = bit_cnt + BIT_CNT_W'(1);
                    end else if (scl_fall && byte_done) begin
                        if (shifter[7:1] == I2C_ADDR) begin
                            state_nxt = ST_ADDR_ACK;
                            oen_nxt   = I2C_ACK;
                        end else begin
                            state_nxt = ST_IGNORE;
                            oen_nxt   = 1'b1;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        cnt_nxt = '0;
                        if (shifter[0]) begin
                            state_nxt = ST_RD;
                            rd_nxt    = 1'b1;
                            oen_nxt   = reg_rdat_i[7];
                        end else begin
                            state_nxt = ST_PTR;
                            oen_nxt   = 1'b1;
                        end
                    end
                end
                ST_PTR: begin
                    if (scl_rise) begin
                        shift_nxt = shift_in;
                        cnt_nxt   = bit_cnt + BIT_CNT_W'(1);
                    end else if (scl_fall && byte_done) begin
                        state_nxt = ST_PTR_ACK;
                        oen_nxt   = I2C_ACK;
                    end
                end
                ST_PTR_ACK: begin
                    if (scl_fall) begin
                        ptr_nxt   = shifter[REG_AW-1:0];
                        state_nxt = ST_WR;
                        cnt_nxt   = '0;
                        oen_nxt   = 1'b1;
                    end
                end
                ST_WR: begin
                    if (scl_rise) begin
                        shift_nxt = shift_in;
                        cnt_nxt   = bit_cnt + BIT_CNT_W'(1);
                        if (bit_cnt == BIT_CNT_W'(7)) begin
                            wdat_nxt = shift_in;
                            wr_nxt   = 1'b1;
                        end
                    end else if (scl_fall && byte_done) begin
                        state_nxt = ST_WR_ACK;
                        oen_nxt   = I2C_ACK;
                    end
                end
                ST_WR_ACK: begin
                    if (scl_fall) begin
                        state_nxt = ST_WR;
                        cnt_nxt   = '0;
                        oen_nxt   = 1'b1;
                    end
                end
                ST_RD: begin
                    if (scl_rise) begin
                        cnt_nxt = bit_cnt + BIT_CNT_W'(1);
                    end else if (scl_fall) begin
                        if (byte_done) begin
                            state_nxt = ST_RD_ACK;
                            oen_nxt   = 1'b1;
                        end else begin
                            oen_nxt = shifter[rd_idx];
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        ack_nxt = sda;
                    end else if (scl_fall) begin
                        cnt_nxt = '0;
                        if (ack_bit == I2C_ACK) begin
                            state_nxt = ST_RD;
                            rd_nxt    = 1'b1;
                            oen_nxt   = reg_rdat_i[7];
                        end else begin
                            state_nxt = ST_IGNORE;
                            oen_nxt   = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda_pad_o    = 1'b0;
    assign sda_padoen_o = sda_oen;
    assign reg_addr_o   = ptr;
    assign reg_wdat_o   = wdat;
    assign reg_wr_o     = reg_wr;
    assign reg_rd_o     = reg_rd;
    assign busy_o       = busy;

endmodule

// File: doc/i2c_slave_regs.md
# i2c_slave_regs

I2C target (slave) that gives an external I2C master access to an 8-bit-wide register space inside the FPGA. It is the far-end counterpart of our Wishbone/Avalon I2C master core. It sits on the same open-drain SCL/SDA pad pair and turns bus transactions into single-cycle register read/write strobes on the `wb_clk_i` domain. It supports a register pointer with auto-increment, repeated START, and ACK/NACK generation.

## Interface
- `I2C_ADDR`, 7'h42, 7-bit target address matched after START.
- `REG_AW`, 8, register pointer width; the pointer is loaded from the low `REG_AW` bits of the first write byte.
- `wb_clk_i` in 1: system clock; all logic runs on its rising edge.
- `arst_i` in 1: asynchronous, active-low reset.
- `scl_pad_i` in 1: raw SCL level from the pad; the block never drives SCL.
- `sda_pad_i` in 1: raw SDA level from the pad.
- `sda_pad_o` out 1: SDA output value, tied to 0 (open drain).
- `sda_padoen_o` out 1: SDA output enable, active-low; 1 releases SDA (Z), 0 pulls it low.
- `reg_addr_o` out REG_AW: current register pointer.
- `reg_wdat_o` out 8: write data, valid while `reg_wr_o`=1.
- `reg_wr_o` out 1: one-cycle write strobe.
- `reg_rd_o` out 1: one-cycle strobe; `reg_rdat_i` is captured in that same cycle.
- `reg_rdat_i` in 8: read data. Must be combinationally valid for `reg_addr_o`.
- `busy_o` out 1: high from START to STOP.

## Operation
- SCL and SDA pass through 2-FF synchronizers, then edge detection.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
- Input data is sampled on SCL rising edges. `sda_padoen_o` changes only in the cycle after a detected SCL falling edge.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE.
- START in any state → ADDR. The bit counter clears and SDA is released.
- STOP in any state → IDLE. SDA is released and `busy_o` drops.
- ADDR: shift 8 bits, MSB first.
  - If `addr[7:1]`==I2C_ADDR → ADDR_ACK and pull SDA low for the 9th clock.
  - On mismatch → IGNORE, with SDA released and no ACK.
- After ADDR_ACK with R/W=0 → PTR. After PTR_ACK, the pointer is loaded, then → WR.
- After ADDR_ACK with R/W=1 → RD. Reads start from the current pointer, which persists across transactions.
- WR: on the 8th sampled bit, set `reg_wdat_o` and pulse `reg_wr_o` once. Then ACK and increment the pointer after the strobe.
- RD: on the SCL falling edge that ends the ACK, pulse `reg_rd_o`, capture `reg_rdat_i` into the shifter, and increment the pointer. Drive SDA low for 0 bits and release it for 1 bits.
- RD_ACK: release SDA and sample the master's bit.
  - ACK (0) → RD, next byte.
  - NACK (1) → IGNORE until STOP/START.
- The pointer wraps modulo 2^REG_AW.

## Timing
- SCL high and low phases must each be ≥4 `wb_clk_i` cycles (≥6 with the filter enabled).
- Input latency: 2 cycles (+2 with the filter enabled).
- `reg_wr_o` asserts 1 cycle after the synchronized 8th SCL rising edge.
- `reg_rd_o` asserts 1 cycle after the synchronized SCL falling edge.
- Reset values: `sda_padoen_o`=1, `sda_pad_o`=0, `reg_addr_o`=0, `reg_wdat_o`=0, `reg_wr_o`=0, `reg_rd_o`=0, `busy_o`=0. FSM resets to IDLE and all synchronizer flops to 1.
- Reset asserted mid-transaction releases SDA immediately (asynchronously). A STOP or START mid-byte discards the partial byte, with no strobe.

## Configuration
- `I2C_SLAVE_GLITCH_FILTER_EN` defined: after the synchronizers, SCL and SDA each pass through a 3-sample majority filter. Single-cycle glitches are rejected, and latency grows by 2 cycles.
- Not defined: synchronizer outputs feed edge detection directly.

## Structure
- Shared package `i2c_slave_pkg` holds:
  - the FSM state enum;
  - `I2C_ACK`=1'b0 and `I2C_NACK`=1'b1;
  - the bit-count width constant (4).
- Sub-module `i2c_slave_line_cond` handles synchronizer + optional filter + SCL rise/fall and START/STOP detection. One instance covers both lines.

## Test plan
- Write: START, 0x84, 0x10, 0xA5, 0x5A, STOP → four ACKs, `reg_wr_o` pulses at addr 0x10 with 0xA5 and at 0x11 with 0x5A; final pointer is 0x12.
- Repeated-start read: START, 0x84, 0x20, Sr, 0x85, read 2 bytes (ACK, then NACK), STOP, with the model returning addr+1 → bytes 0x21, 0x22; `reg_rd_o` pulses exactly twice.
- Address mismatch: START, 0x90, 0x00, STOP → SDA never pulled low; no strobes; `busy_o` is 1 between START and STOP.
- STOP after 4 data bits in WR → no `reg_wr_o`, FSM returns to IDLE, and the next transaction works normally.
- Pointer wrap: write pointer 0xFF, then data 0x11, 0x22 → writes land at 0xFF and then 0x00.
- `arst_i` low during ADDR_ACK (SDA held low) → SDA released in the same cycle; all outputs take their reset values.
